// File: rtl/path_stim_gen.sv
// Timing-path stimulus generator: launches a patterned burst into a path and
// checks the captured return against the launched beats after lat+1 cycles.
//
// state | meaning
// IDLE  | waiting for start; counters hold the last burst's results
// RUN   | one beat on launch per cycle, N cycles
// DRAIN | lat+1 cycles so the last beats reach the compare tap
// DONE  | one-cycle done pulse, then back to IDLE
module path_stim_gen #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [1:0]       lat,
  input  logic             ret,
  output logic             launch,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] sent_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [1:0]       lat_q;
  logic [1:0]       drain_cnt;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       lfsr;
  logic [3:0]       exp_d;
  logic [3:0]       exp_v;

  logic [7:0] lfsr_next;
  logic       next_beat;
  logic       last_beat;
  logic       mismatch;

  always_comb begin
    lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
    last_beat = (sent_cnt == (len_q - LEN_W'(1)));
    mismatch  = ((state == RUN) || (state == DRAIN)) && exp_v[lat_q] && (exp_d[lat_q] != ret);
    next_beat = 1'b0;
    case (mode_q)
      2'b00:   next_beat = 1'b0;
      2'b01:   next_beat = 1'b1;
      2'b10:   next_beat = ~launch;
      default: next_beat = lfsr_next[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      lat_q     <= 2'b00;
      drain_cnt <= 2'b00;
      len_q     <= '0;
      lfsr      <= 8'h01;
      exp_d     <= 4'b0000;
      exp_v     <= 4'b0000;
      launch    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent_cnt  <= '0;
      err_cnt   <= 8'h00;
    end else begin
      // Expected-value pipe: entry i holds the beat launched i+1 cycles ago.
      exp_d <= {exp_d[2:0], launch};
      exp_v <= {exp_v[2:0], (state == RUN)};
      if (mismatch && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;

      case (state)
        IDLE: begin
          launch <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            mode_q   <= mode;
            len_q    <= burst_len;
            lat_q    <= lat;
            sent_cnt <= '0;
            err_cnt  <= 8'h00;
            lfsr     <= 8'h01;
            // Stale entries deeper than the old tap must not leak into a new burst.
            exp_v    <= 4'b0000;
            busy     <= 1'b1;
            if (burst_len != '0) begin
              state  <= RUN;
              // Beat 0: const-1 and the LFSR seed's bit 0 are both 1.
              launch <= mode[0];
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          sent_cnt <= sent_cnt + LEN_W'(1);
          lfsr     <= lfsr_next;
          if (last_beat) begin
            state     <= DRAIN;
            launch    <= 1'b0;
            drain_cnt <= lat_q;
          end else begin
            launch <= next_beat;
          end
        end

        DRAIN: begin
          if (drain_cnt == 2'b00) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          launch <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_stim_gen.sv
// Bench for path_stim_gen: table-driven scenarios, randomized bursts against a
// beat-list model, and hand-written reset / zero-length sequences.
module tb_path_stim_gen;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [LEN_W-1:0] burst_len = '0;
  logic [1:0]       lat = 2'b00;
  logic             ret = 1'b0;
  logic             launch, busy, done;
  logic [LEN_W-1:0] sent_cnt;
  logic [7:0]       err_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int m;
    int n;
    int l;
    int rmode;    // 0 tie0, 1 tie1, 2 launch delayed lat+1, 3 random
    int exp_err;  // -1: take the model's count
  } vec_t;

  vec_t tbl[6];

  path_stim_gen #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .burst_len(burst_len),
    .lat(lat), .ret(ret), .launch(launch), .busy(busy), .done(done),
    .sent_cnt(sent_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Beat sequence straight from the pattern rules.
  function automatic int model_beat(input int m, input int k);
    int l, fb;
    case (m)
      0: return 0;
      1: return 1;
      2: return k % 2;
      default: begin
        l = 1;
        for (int j = 0; j < k; j++) begin
          fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 4)) & 1;
          l  = (l >> 1) | (fb << 7);
        end
        return l & 1;
      end
    endcase
  endfunction

  task automatic run_burst(input int m, input int n, input int l, input int rmode, input int exp_err);
    int beats[$];
    int rh[$];
    int lo[$];
    int e, last, got_sent, got_err, x;
    last = n + l + 1;
    for (int k = 0; k < n; k++) beats.push_back(model_beat(m, k));
    @(negedge clk);
    start = 1'b1; mode = 2'(m); burst_len = LEN_W'(n); lat = 2'(l); ret = 1'b0;
    got_sent = 0; got_err = 0;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      chk("launch", launch, (i < n) ? beats[i] : 0);
      chk("busy", busy, 1);
      chk("done", done, (i == last) ? 1 : 0);
      lo.push_back(int'(launch));
      if (i == last) begin
        got_sent = sent_cnt;
        got_err  = err_cnt;
      end
      // Config and start churn mid-burst must be ignored.
      start = (i == last) ? 1'b0 : 1'($urandom_range(0, 1));
      mode = 2'($urandom); burst_len = LEN_W'($urandom); lat = 2'($urandom);
      case (rmode)
        0: x = 0;
        1: x = 1;
        2: x = (i >= l + 1) ? lo[i - l - 1] : 0;
        default: x = int'($urandom_range(0, 1));
      endcase
      ret = 1'(x);
      rh.push_back(x);
    end
    e = 0;
    for (int k = 0; k < n; k++) if (beats[k] != rh[k + l + 1]) e++;
    if (e > 255) e = 255;
    if (exp_err >= 0) e = exp_err;
    chk("sent_cnt_at_done", got_sent, n);
    chk("err_cnt_at_done", got_err, e);
    @(negedge clk);
    start = 1'b0; ret = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_launch", launch, 0);
    chk("idle_sent_hold", sent_cnt, n);
    chk("idle_err_hold", err_cnt, e);
  endtask

  initial begin
    tbl[0] = '{2, 6,   0, 2, 0};    // toggle, ret = launch delayed
    tbl[1] = '{1, 4,   3, 0, 4};    // const-1 vs tie-0, long drain
    tbl[2] = '{3, 8,   1, 2, 0};    // LFSR, ret = launch delayed
    tbl[3] = '{0, 5,   2, 1, 5};    // const-0 vs tie-1
    tbl[4] = '{2, 7,   2, 0, 3};    // toggle 0101010 vs tie-0
    tbl[5] = '{1, 255, 1, 0, 255};  // max length, err saturates

    // Reset state; start held high while rst_n low must do nothing.
    start = 1'b1; burst_len = 8'd5; mode = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_launch", launch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_err", err_cnt, 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // LFSR leading beats from seed 8'h01.
    chk("lfsr_beat0", model_beat(3, 0), 1);
    chk("lfsr_beat1", model_beat(3, 1), 0);

    for (int t = 0; t < 6; t++)
      run_burst(tbl[t].m, tbl[t].n, tbl[t].l, tbl[t].rmode, tbl[t].exp_err);

    // Zero-length burst: done next cycle, no beats, counters clear.
    @(negedge clk);
    start = 1'b1; burst_len = '0; mode = 2'b01; lat = 2'd3;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_launch", launch, 0);
    chk("zero_sent", sent_cnt, 0);
    chk("zero_err", err_cnt, 0);
    @(negedge clk);
    chk("zero_done_clear", done, 0);
    chk("zero_busy_clear", busy, 0);
    chk("zero_launch_idle", launch, 0);

    // Reset during RUN at beat 3, then a clean burst.
    @(negedge clk);
    start = 1'b1; mode = 2'b01; burst_len = 8'd10; lat = 2'd1; ret = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_beat3_launch", launch, 1);
    chk("abort_beat3_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_launch", launch, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_sent", sent_cnt, 0);
    chk("async_err", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle_busy", busy, 0);
    end
    run_burst(1, 2, 0, 0, 2);

    // Randomized bursts against the model.
    for (int r = 0; r < 20; r++)
      run_burst(int'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/path_stim_gen.md
PATH_STIM_GEN -- requirements
Module: path_stim_gen

Interface
REQ-001 The block SHALL expose parameter LEN_W, default 8, giving the width of the burst length and sent-beat count.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: burst request; honoured only in IDLE.
REQ-005 Port mode, input, 2 bits: pattern select; 00 const-0, 01 const-1, 10 toggle, 11 LFSR.
REQ-006 Port burst_len, input, LEN_W bits: number of beats to launch.
REQ-007 Port lat, input, 2 bits: expected path latency; return delay SHALL be lat+1 cycles (range 1..4).
REQ-008 Port ret, input, 1 bit: captured output of the downstream timing path.
REQ-009 Port launch, output, 1 bit: drives the timing path data input.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.
REQ-011 Port done, output, 1 bit: single-cycle completion pulse.
REQ-012 Port sent_cnt, output, LEN_W bits: beats launched in the current or last burst.
REQ-013 Port err_cnt, output, 8 bits: return mismatches, saturating.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE -> RUN SHALL occur on the edge where start=1 and burst_len!=0.
- On that edge, mode, burst_len and lat SHALL be latched.
- On that edge, sent_cnt and err_cnt SHALL clear and the LFSR SHALL load seed 8'h01.
REQ-016 IDLE -> DONE SHALL occur on start=1 with burst_len=0; no beat SHALL be launched and the counters SHALL clear.
REQ-017 start SHALL be ignored in RUN, DRAIN and DONE; config changes SHALL have no effect mid-burst.
REQ-018 In RUN, beat k (k=0..N-1) SHALL be driven on launch during the k-th RUN cycle, and sent_cnt SHALL increment by 1 per beat.
REQ-019 RUN -> DRAIN SHALL occur after beat N-1 is driven, i.e. after exactly N RUN cycles.
REQ-020 Pattern values:
- const-0: every beat is 0.
- const-1: every beat is 1.
- toggle: beat 0 is 0, then each beat alternates.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, launch=lfsr[0], advancing once per beat.
REQ-021 launch SHALL be 0 in IDLE, DRAIN and DONE.
REQ-022 Each launched beat SHALL enter a 4-deep expected-value shift register with a per-entry valid bit.
REQ-023 Beat k SHALL be compared with ret exactly lat+1 cycles after it was driven.
- On mismatch, err_cnt SHALL increment.
- err_cnt SHALL hold at 255 once reached.
REQ-024 DRAIN SHALL last exactly lat+1 cycles so the last beat is compared, then SHALL go to DONE.
REQ-025 DONE SHALL last one cycle with done=1, then SHALL return to IDLE; done SHALL be 0 in all other states.
REQ-026 sent_cnt and err_cnt SHALL hold their final values in IDLE until the next accepted start.
REQ-027 ret SHALL be ignored when no valid expected entry is at the compare tap.
REQ-028 A burst_len of 2^LEN_W-1 SHALL complete without sent_cnt wrap.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force the following, regardless of clk:
- state IDLE;
- launch, busy and done to 0;
- sent_cnt and err_cnt to 0;
- LFSR to 8'h01;
- all expected-register valid bits to 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no done pulse; the first start after deassertion SHALL begin a clean burst.
REQ-031 No input SHALL take effect on the first clk edge coincident with rst_n deassertion if rst_n is still sampled low.

Verification
REQ-032 Scenario: mode=10, burst_len=6, lat=0, ret=launch delayed 1 cycle -> launch shows 0,1,0,1,0,1; done 8 cycles after start (6 RUN + 1 DRAIN + DONE); sent_cnt=6; err_cnt=0.
REQ-033 Scenario: mode=01, burst_len=4, lat=3, ret tied 0 -> err_cnt=4; DRAIN lasts 4 cycles; busy high 4+4+1 cycles.
REQ-034 Scenario: mode=11, burst_len=8, lat=1, ret=launch delayed 2 cycles -> launch shows 1,0,0,0,... matching LFSR from seed 8'h01; err_cnt=0.
REQ-035 Scenario: start with burst_len=0 -> done pulses on the next cycle; launch stays 0; sent_cnt=0.
REQ-036 Scenario: mode=01, burst_len=255, ret tied 0 -> err_cnt saturates at 255; sent_cnt=255, no wrap.
REQ-037 Scenario: rst_n pulsed low during RUN at beat 3, then a new start with burst_len=2 -> outputs clear asynchronously; no done for the aborted burst; the new burst gives sent_cnt=2.
